// File: rtl/axis_m.sv
// ---------------------------------------------------------------------------
// axis_m : AXI4-Stream packet source.
//
// A single-cycle request on newd captures din as a seed. The block then emits
// BURST_LEN beats (seed, seed+1, ... modulo 2^DATA_WIDTH) on the master port
// and marks the final beat with tlast. Requests that arrive while a packet is
// being sent are dropped. At least one idle cycle follows every packet.
//
// Ports
//   m_axis_aclk    in   1           clock, rising edge
//   m_axis_aresetn in   1           asynchronous reset, active low
//   newd           in   1           start request, sampled only when idle
//   din            in   DATA_WIDTH  packet seed, captured together with newd
//   m_axis_tdata   out  DATA_WIDTH  stream data
//   m_axis_tvalid  out  1           beat valid
//   m_axis_tready  in   1           sink ready
//   m_axis_tlast   out  1           final beat of the packet
// ---------------------------------------------------------------------------
module axis_m #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  newd,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int unsigned BEAT_W = (BURST_LEN <= 1) ? 1 : $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q,  state_d;
  logic [BEAT_W-1:0]       beat_q,   beat_d;
  logic [DATA_WIDTH-1:0]   seed_q,   seed_d;
  logic [DATA_WIDTH-1:0]   tdata_q,  tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q,  tlast_d;
  logic [BEAT_W-1:0]       beat_nxt;

  // Beat payload: seed plus beat index, carry out of the top bit discarded.
  function automatic logic [DATA_WIDTH-1:0] beat_data(
    input logic [DATA_WIDTH-1:0] seed,
    input logic [BEAT_W-1:0]     beat
  );
    return seed + DATA_WIDTH'(beat);
  endfunction

  // Only evaluated while beat_q < LAST_BEAT, so it cannot overflow.
  assign beat_nxt = beat_q + BEAT_W'(1);

  // Next-state and next-output logic. The outputs are computed one cycle
  // ahead and registered, so tvalid never depends combinationally on tready.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    seed_d   = seed_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;

    unique case (state_q)
      IDLE: begin
        tdata_d  = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (newd) begin
          state_d  = SEND;
          seed_d   = din;
          beat_d   = '0;
          tdata_d  = din;
          tvalid_d = 1'b1;
          tlast_d  = (LAST_BEAT == '0);
        end
      end

      SEND: begin
        // Without a handshake every output holds (AXIS stability).
        if (tvalid_q && m_axis_tready) begin
          if (beat_q == LAST_BEAT) begin
            // Final beat accepted: the cycle after is always idle, even if
            // newd is already high, which gives the mandatory packet gap.
            state_d  = IDLE;
            beat_d   = '0;
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            beat_d   = beat_nxt;
            tdata_d  = beat_data(seed_q, beat_nxt);
            tvalid_d = 1'b1;
            tlast_d  = (beat_nxt == LAST_BEAT);
          end
        end
      end

      default: begin
        state_d  = IDLE;
        beat_d   = '0;
        tdata_d  = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // State, counter, seed and output registers. Everything clears
  // asynchronously so the port drops to zero as soon as reset asserts.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      seed_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      seed_q   <= seed_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_m.sv
// Testbench for axis_m: scoreboard of expected beats plus per-scenario tasks.
module tb_axis_m;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk;
  logic          rst_n;
  logic          newd;
  logic [DW-1:0] din;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  int checks;
  int failures;
  int hs_count;

  // Expected beats, {tlast, tdata}.
  logic [DW:0] exp_q[$];

  axis_m #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .newd          (newd),
    .din           (din),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: inputs change only just after a rising edge, so at the
  // falling edge tvalid&tready tells whether the next rising edge handshakes.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      logic [DW:0] e;
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got beat data=%02h last=%0b, want no beat", tdata, tlast);
      end else begin
        e = exp_q.pop_front();
        if ({tlast, tdata} !== e) begin
          failures++;
          $display("FAIL sb_beat: got data=%02h last=%0b, want data=%02h last=%0b",
                   tdata, tlast, e[DW-1:0], e[DW]);
        end
      end
    end
  end

  task automatic push_packet(input logic [DW-1:0] seed);
    for (int i = 0; i < BL; i++) begin
      logic [DW-1:0] d;
      d = seed + DW'(i);
      exp_q.push_back({(i == BL - 1), d});
    end
  endtask

  // Issue a one-cycle request; returns #1 after the accepting edge.
  task automatic start_packet(input logic [DW-1:0] seed);
    din  = seed;
    newd = 1'b1;
    push_packet(seed);
    @(posedge clk); #1;
    newd = 1'b0;
  endtask

  // Wait for the final handshake; returns #1 after that edge.
  task automatic wait_last(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tvalid && tready && tlast) begin
        @(posedge clk); #1;
        ok = 1'b1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL wait_last: got no tlast handshake in 40 cycles, want one");
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    newd   = 1'b0;
    din    = '0;
    tready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({tvalid, tlast, tdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b l=%0b d=%02h, want 0 0 00", tvalid, tlast, tdata);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tvalid, tlast, tdata} !== '0) begin
      failures++;
      $display("FAIL reset_release_idle: got v=%0b l=%0b d=%02h, want 0 0 00", tvalid, tlast, tdata);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int hs0;
    hs0    = hs_count;
    tready = 1'b1;
    start_packet(8'h24);
    checks++;
    if (!(tvalid === 1'b1 && tdata === 8'h24 && tlast === 1'b0)) begin
      failures++;
      $display("FAIL basic_latency: got v=%0b d=%02h l=%0b, want 1 24 0", tvalid, tdata, tlast);
    end
    wait_last(ok);
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL basic_gap: got v=%0b l=%0b, want 0 0", tvalid, tlast);
    end
    checks++;
    if (hs_count - hs0 != BL) begin
      failures++;
      $display("FAIL basic_count: got %0d handshakes, want %0d", hs_count - hs0, BL);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int hs0;
    hs0    = hs_count;
    tready = 1'b1;
    start_packet(8'h10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (!(tvalid === 1'b1 && tdata === 8'h12 && tlast === 1'b0)) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%0b d=%02h l=%0b, want 1 12 0", i, tvalid, tdata, tlast);
      end
    end
    tready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!(tvalid === 1'b1 && tdata === 8'h13 && tlast === 1'b1)) begin
      failures++;
      $display("FAIL bp_resume: got v=%0b d=%02h l=%0b, want 1 13 1", tvalid, tdata, tlast);
    end
    wait_last(ok);
    checks++;
    if (hs_count - hs0 != BL) begin
      failures++;
      $display("FAIL bp_count: got %0d handshakes, want %0d", hs_count - hs0, BL);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    tready = 1'b1;
    start_packet(8'hFE);
    wait_last(ok);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain: got %0d beats left, want 0", exp_q.size());
    end
  endtask

  task automatic test_ignored();
    bit ok;
    tready = 1'b1;
    start_packet(8'h40);
    din  = 8'h99;
    newd = 1'b1;
    @(posedge clk); #1;
    newd = 1'b0;
    checks++;
    if (tdata !== 8'h41) begin
      failures++;
      $display("FAIL ignored_data: got %02h, want 41", tdata);
    end
    wait_last(ok);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (tvalid !== 1'b0) begin
        failures++;
        $display("FAIL ignored_no_packet[%0d]: got tvalid=%0b, want 0", i, tvalid);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int falls;
    logic [DW-1:0] seed;
    falls  = 0;
    tready = 1'b1;
    seed   = DW'($urandom_range(0, 255));
    din    = seed;
    newd   = 1'b1;
    push_packet(seed);
    for (int p = 0; p < 5; p++) begin
      wait_last(ok);
      if (ok) falls++;
      checks++;
      if (tvalid !== 1'b0 || tlast !== 1'b0) begin
        failures++;
        $display("FAIL b2b_gap[%0d]: got v=%0b l=%0b, want 0 0", p, tvalid, tlast);
      end
      if (p < 4) begin
        seed = DW'($urandom_range(0, 255));
        din  = seed;
        push_packet(seed);
        @(posedge clk); #1;
        checks++;
        if (!(tvalid === 1'b1 && tdata === seed)) begin
          failures++;
          $display("FAIL b2b_restart[%0d]: got v=%0b d=%02h, want 1 %02h", p, tvalid, tdata, seed);
        end
      end else begin
        newd = 1'b0;
      end
    end
    checks++;
    if (falls != 5) begin
      failures++;
      $display("FAIL b2b_packets: got %0d packets, want 5", falls);
    end
  endtask

  task automatic test_async_reset();
    tready = 1'b1;
    start_packet(8'h30);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (tdata !== 8'h32) begin
      failures++;
      $display("FAIL areset_setup: got %02h, want 32", tdata);
    end
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({tvalid, tlast, tdata} !== '0) begin
      failures++;
      $display("FAIL areset_immediate: got v=%0b l=%0b d=%02h, want 0 0 00", tvalid, tlast, tdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({tvalid, tlast, tdata} !== '0) begin
        failures++;
        $display("FAIL areset_no_resume[%0d]: got v=%0b l=%0b d=%02h, want 0 0 00", i, tvalid, tlast, tdata);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hs_count = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_ignored();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain: got %0d beats left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
